// File: rtl/pwm_bank_pkg.sv
// Shared register-window layout for the PWM bank: word offsets and CTRL field positions.
package pwm_bank_pkg;

    localparam logic [3:0] OFF_CTRL   = 4'd0;
    localparam logic [3:0] OFF_PERIOD = 4'd1;
    localparam logic [3:0] OFF_PRESC  = 4'd2;
    localparam logic [3:0] OFF_STATUS = 4'd3;
    localparam logic [3:0] OFF_DUTY0  = 4'd4;

    localparam int FORCE_BIT = 31;
    localparam int EN_LSB    = 0;
    localparam int INV_LSB   = 8;

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compares the shared period counter against this channel's active duty,
// applies enable/polarity and registers the result.
module pwm_channel #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W-1:0] duty_act,
    input  logic             en,
    input  logic             inv,
    output logic             pwm
);

    logic pwm_d;
    logic pwm_q;

    // A disabled channel idles at its inactive level, which is the polarity bit itself.
    always_comb begin
        pwm_d = inv;
        if (en) begin
            pwm_d = (cnt < duty_act) ^ inv;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pwm_q <= 1'b0;
        end else begin
            pwm_q <= pwm_d;
        end
    end

    assign pwm = pwm_q;

endmodule

// File: rtl/pwm_bank.sv
// Memory-mapped multi-channel PWM: bus decode, double-buffered period/duty, shared
// prescaler and period counter, commit logic and registered read-back.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 16,
    parameter int          PRESC_W   = 8,
    parameter logic [11:0] BASE_ADDR = 12'hF00
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wren,
    input  logic [11:0]       address,
    input  logic [31:0]       data,
    output logic [31:0]       q,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick
);

    localparam logic [3:0] NUM_CH4 = 4'(NUM_CH);

    logic [NUM_CH-1:0]  en_q, en_d;
    logic [NUM_CH-1:0]  inv_q, inv_d;
    logic [CNT_W-1:0]   period_sh_q, period_sh_d;
    logic [CNT_W-1:0]   per_act_q, per_act_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [CNT_W-1:0]   duty_sh_q [NUM_CH];
    logic [CNT_W-1:0]   duty_sh_d [NUM_CH];
    logic [CNT_W-1:0]   duty_act_q [NUM_CH];
    logic [CNT_W-1:0]   duty_act_d [NUM_CH];
    logic               tick_q, tick_d;
    logic [31:0]        rdata_q, rdata_d;

    logic       sel;
    logic       wr;
    logic [3:0] off;
    logic [3:0] duty_idx;
    logic       duty_hit;
    logic       force_req;
    logic       presc_tick;
    logic       wrap;
    logic       commit;

    logic [CNT_W+PRESC_W-1:0] status_w;
    logic                     unused_data;

    assign unused_data = ^data;
    assign status_w    = {pcnt_q, cnt_q};

    always_comb begin
        off        = address[3:0];
        sel        = (address[11:4] == BASE_ADDR[11:4]);
        wr         = wren & sel;
        duty_idx   = off - OFF_DUTY0;
        duty_hit   = (off >= OFF_DUTY0) && (duty_idx < NUM_CH4);
        force_req  = wr && (off == OFF_CTRL) && data[FORCE_BIT];
        presc_tick = (pcnt_q >= presc_q);
        wrap       = presc_tick && (cnt_q == per_act_q);
        commit     = wrap | force_req;
    end

    // Register writes; a write coinciding with a commit lands in the shadow only,
    // because the commit below samples the shadow's current (old) value.
    always_comb begin
        en_d        = en_q;
        inv_d       = inv_q;
        period_sh_d = period_sh_q;
        presc_d     = presc_q;
        for (int i = 0; i < NUM_CH; i++) begin
            duty_sh_d[i]  = duty_sh_q[i];
            duty_act_d[i] = commit ? duty_sh_q[i] : duty_act_q[i];
            if (wr && duty_hit && (duty_idx == 4'(i))) begin
                duty_sh_d[i] = data[CNT_W-1:0];
            end
        end
        if (wr) begin
            case (off)
                OFF_CTRL: begin
                    en_d  = data[EN_LSB +: NUM_CH];
                    inv_d = data[INV_LSB +: NUM_CH];
                end
                OFF_PERIOD: period_sh_d = data[CNT_W-1:0];
                OFF_PRESC:  presc_d     = data[PRESC_W-1:0];
                default:    ;
            endcase
        end
    end

    // Counters only ever return to zero through the compares, so they cannot overflow.
    always_comb begin
        per_act_d = commit ? period_sh_q : per_act_q;
        tick_d    = commit;
        pcnt_d    = presc_tick ? '0 : pcnt_q + 1'b1;
        cnt_d     = cnt_q;
        if (presc_tick) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
        end
        if (force_req) begin
            pcnt_d = '0;
            cnt_d  = '0;
        end
    end

    always_comb begin
        rdata_d = '0;
        if (sel) begin
            case (off)
                OFF_CTRL: begin
                    rdata_d[EN_LSB +: NUM_CH]  = en_q;
                    rdata_d[INV_LSB +: NUM_CH] = inv_q;
                end
                OFF_PERIOD: rdata_d[CNT_W-1:0]         = period_sh_q;
                OFF_PRESC:  rdata_d[PRESC_W-1:0]       = presc_q;
                OFF_STATUS: rdata_d[CNT_W+PRESC_W-1:0] = status_w;
                default: begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (duty_hit && (duty_idx == 4'(i))) begin
                            rdata_d[CNT_W-1:0] = duty_sh_q[i];
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            en_q        <= '0;
            inv_q       <= '0;
            period_sh_q <= '0;
            per_act_q   <= '0;
            cnt_q       <= '0;
            presc_q     <= '0;
            pcnt_q      <= '0;
            tick_q      <= 1'b0;
            rdata_q     <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            en_q        <= en_d;
            inv_q       <= inv_d;
            period_sh_q <= period_sh_d;
            per_act_q   <= per_act_d;
            cnt_q       <= cnt_d;
            presc_q     <= presc_d;
            pcnt_q      <= pcnt_d;
            tick_q      <= tick_d;
            rdata_q     <= rdata_d;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i]  <= duty_sh_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            pwm_channel #(
                .CNT_W(CNT_W)
            ) u_ch (
                .clock   (clock),
                .reset   (reset),
                .cnt     (cnt_q),
                .duty_act(duty_act_q[gi]),
                .en      (en_q[gi]),
                .inv     (inv_q[gi]),
                .pwm     (pwm_out[gi])
            );
        end
    endgenerate

    assign q           = rdata_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: register table, directed PWM scenarios and
// randomized bus traffic compared every cycle against a reference model.
module tb_pwm_bank;

    localparam int NCH = 4;

    logic           clock;
    logic           reset;
    logic           wren;
    logic [11:0]    address;
    logic [31:0]    data;
    logic [31:0]    q;
    logic [NCH-1:0] pwm_out;
    logic           period_tick;

    int n_checks;
    int n_fail;

    pwm_bank #(
        .NUM_CH   (NCH),
        .CNT_W    (16),
        .PRESC_W  (8),
        .BASE_ADDR(12'hF00)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .wren       (wren),
        .address    (address),
        .data       (data),
        .q          (q),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model state, named after the programmer-visible quantities.
    int unsigned    m_prescale;
    int unsigned    m_presc_count;
    int unsigned    m_position;
    int unsigned    m_period_live;
    int unsigned    m_period_pending;
    int unsigned    m_duty_live [NCH];
    int unsigned    m_duty_pending [NCH];
    bit [NCH-1:0]   m_enable;
    bit [NCH-1:0]   m_invert;
    bit [NCH-1:0]   m_pwm;
    bit             m_tick;
    bit [31:0]      m_q;

    task automatic model_step();
        bit          in_win;
        bit          wr;
        bit          forced;
        bit          step_due;
        bit          period_done;
        int unsigned off;
        bit [31:0]   rd;
        if (!reset) begin
            m_prescale = 0; m_presc_count = 0; m_position = 0;
            m_period_live = 0; m_period_pending = 0;
            m_enable = '0; m_invert = '0; m_pwm = '0; m_tick = 0; m_q = 0;
            for (int i = 0; i < NCH; i++) begin
                m_duty_live[i] = 0;
                m_duty_pending[i] = 0;
            end
            return;
        end
        in_win = (address[11:4] == 8'hF0);
        off    = int'(address[3:0]);
        wr     = wren && in_win;
        rd     = 0;
        if (in_win) begin
            if (off == 0)      rd = (32'(m_invert) << 8) | 32'(m_enable);
            else if (off == 1) rd = m_period_pending;
            else if (off == 2) rd = m_prescale;
            else if (off == 3) rd = (m_presc_count << 16) | m_position;
            else if (off >= 4 && off < 4 + NCH) rd = m_duty_pending[off-4];
        end
        for (int i = 0; i < NCH; i++) begin
            m_pwm[i] = m_enable[i] ? ((m_position < m_duty_live[i]) ^ m_invert[i]) : m_invert[i];
        end
        forced      = wr && (off == 0) && data[31];
        step_due    = (m_presc_count >= m_prescale);
        period_done = step_due && (m_position == m_period_live);
        if (period_done || forced) begin
            m_period_live = m_period_pending;
            for (int i = 0; i < NCH; i++) m_duty_live[i] = m_duty_pending[i];
        end
        if (forced) begin
            m_position = 0; m_presc_count = 0;
        end else if (step_due) begin
            m_presc_count = 0;
            m_position = period_done ? 0 : m_position + 1;
        end else begin
            m_presc_count = m_presc_count + 1;
        end
        m_tick = period_done || forced;
        m_q    = rd;
        if (wr) begin
            if (off == 0) begin
                m_enable = data[NCH-1:0];
                m_invert = data[8 +: NCH];
            end else if (off == 1) m_period_pending = data[15:0];
            else if (off == 2) m_prescale = data[7:0];
            else if (off >= 4 && off < 4 + NCH) m_duty_pending[off-4] = data[15:0];
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        n_checks++;
        if ({pwm_out, period_tick, q} !== {m_pwm, m_tick, m_q}) begin
            n_fail++;
            $display("FAIL model t=%0t pwm_out=%b want %b tick=%b want %b q=%h want %h",
                     $time, pwm_out, m_pwm, period_tick, m_tick, q, m_q);
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] off, input logic [31:0] val);
        address = {8'hF0, off};
        data    = val;
        wren    = 1'b1;
        cycle();
        wren    = 1'b0;
        data    = 32'h0;
    endtask

    task automatic bus_read(input logic [3:0] off, output logic [31:0] val);
        address = {8'hF0, off};
        wren    = 1'b0;
        cycle();
        val = q;
    endtask

    task automatic idle(input int n);
        wren = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_tick(input int bound);
        int k;
        k = 0;
        wren = 1'b0;
        do begin
            cycle();
            k++;
        end while (period_tick !== 1'b1 && k < bound);
        check("tick_timeout", {31'h0, period_tick}, 32'h1);
    endtask

    // Counts clocks with pwm_out[ch]==1 over n idle cycles.
    task automatic count_high(input int ch, input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            highs += int'(pwm_out[ch]);
        end
    endtask

    typedef struct {
        logic [3:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] rand_data(input logic [3:0] off);
        logic [31:0] d;
        case (off)
            4'd0:    d = {($urandom_range(0, 7) == 0), 19'h0, 4'($urandom), 4'h0, 4'($urandom)};
            4'd1:    d = $urandom_range(0, 12);
            4'd2:    d = $urandom_range(0, 3);
            default: d = $urandom_range(0, 14);
        endcase
        if (off != 4'd0 && $urandom_range(0, 5) == 0) d = d | ($urandom & 32'hFFFF_0000);
        return d;
    endfunction

    initial begin
        vec_t        vt [8];
        logic [31:0] rv;
        int          h;
        int          t;
        int          r;
        logic [3:0]  ro;

        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        wren     = 1'b0;
        address  = 12'h0;
        data     = 32'h0;

        idle(3);
        check("reset_pwm", 32'(pwm_out), 32'h0);
        check("reset_q", q, 32'h0);
        check("reset_tick", {31'h0, period_tick}, 32'h0);
        reset = 1'b1;
        idle(2);

        vt[0] = '{4'd1,  32'h1234_ABCD, 32'h0000_ABCD};
        vt[1] = '{4'd2,  32'hFFFF_FF05, 32'h0000_0005};
        vt[2] = '{4'd4,  32'hDEAD_0007, 32'h0000_0007};
        vt[3] = '{4'd7,  32'h0001_FFFF, 32'h0000_FFFF};
        vt[4] = '{4'd0,  32'h8000_F3A5, 32'h0000_0305};
        vt[5] = '{4'd8,  32'hFFFF_FFFF, 32'h0000_0000};
        vt[6] = '{4'd15, 32'h0000_0001, 32'h0000_0000};
        vt[7] = '{4'd5,  32'h0000_0009, 32'h0000_0009};
        for (int i = 0; i < 8; i++) begin
            bus_write(vt[i].off, vt[i].wdata);
            bus_read(vt[i].off, rv);
            $display("reg vec %0d: off=%0d wrote %h read %h", i, vt[i].off, vt[i].wdata, rv);
            check("reg_readback", rv, vt[i].exp);
        end
        address = 12'hE01; data = 32'h55; wren = 1'b1;
        cycle();
        wren = 1'b0;
        bus_read(4'd1, rv);
        check("out_of_window_write", rv, 32'h0000_ABCD);

        // 10-clock period, channel 0 high 3 clocks.
        bus_write(4'd2, 32'd0);
        bus_write(4'd1, 32'd9);
        bus_write(4'd4, 32'd3);
        bus_write(4'd0, 32'h8000_0001);
        h = 0; t = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            h += int'(pwm_out[0]);
            t += int'(period_tick);
        end
        $display("seq1: highs=%0d ticks=%0d over 30 clocks", h, t);
        check("seq1_highs", 32'(h), 32'd9);
        check("seq1_ticks", 32'(t), 32'd3);

        // Mid-period duty change only shows after the next period boundary.
        wait_tick(20);
        bus_write(4'd4, 32'd7);
        h = int'(pwm_out[0]);
        for (int i = 0; i < 9; i++) begin
            cycle();
            h += int'(pwm_out[0]);
        end
        check("seq3_old_shape", 32'(h), 32'd3);
        check("seq3_boundary_tick", {31'h0, period_tick}, 32'h1);
        count_high(0, 10, h);
        $display("seq3: highs after boundary=%0d", h);
        check("seq3_new_shape", 32'(h), 32'd7);

        // Duty write on the wrap cycle: old shadow for one period, then the new one.
        h = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            h += int'(pwm_out[0]);
        end
        bus_write(4'd4, 32'd2);
        h += int'(pwm_out[0]);
        check("seq4_pre_highs", 32'(h), 32'd7);
        check("seq4_wrap_tick", {31'h0, period_tick}, 32'h1);
        count_high(0, 10, h);
        check("seq4_old_value_period", 32'(h), 32'd7);
        count_high(0, 10, h);
        check("seq4_new_value_period", 32'(h), 32'd2);
        $display("seq4: final period highs=%0d", h);

        // Duty above period -> constant active; duty 0 -> constant inactive.
        bus_write(4'd2, 32'd1);
        bus_write(4'd1, 32'd4);
        bus_write(4'd5, 32'd5);
        bus_write(4'd0, 32'h8000_0002);
        idle(1);
        count_high(1, 20, h);
        check("seq2_const_high", 32'(h), 32'd20);
        bus_write(4'd5, 32'd0);
        wait_tick(30);
        idle(1);
        count_high(1, 20, h);
        $display("seq2: ch1 highs with duty 0 = %0d", h);
        check("seq2_const_low", 32'(h), 32'd0);

        // Disabled, inverted channel sits at 1; CTRL reads back.
        bus_write(4'd0, 32'h0000_0100);
        idle(1);
        h = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (pwm_out == 4'b0001) h++;
        end
        check("seq5_steady", 32'(h), 32'd10);
        bus_read(4'd0, rv);
        $display("seq5: ctrl read %h", rv);
        check("seq5_ctrl_read", rv, 32'h0000_0100);

        // Reset in the middle of a period.
        bus_write(4'd2, 32'd0);
        bus_write(4'd1, 32'd9);
        bus_write(4'd4, 32'd6);
        bus_write(4'd0, 32'h8000_0001);
        idle(3);
        address = 12'hF03;
        reset   = 1'b0;
        cycle();
        check("seq6_pwm", 32'(pwm_out), 32'h0);
        check("seq6_q", q, 32'h0);
        check("seq6_tick", {31'h0, period_tick}, 32'h0);
        reset = 1'b1;
        bus_read(4'd3, rv);
        check("seq6_status", rv, 32'h0);
        bus_read(4'd1, rv);
        check("seq6_period_cleared", rv, 32'h0);
        bus_read(4'd15, rv);
        check("seq6_offset15", rv, 32'h0);
        $display("seq6: reset mid-period done");

        // Random traffic checked cycle by cycle against the model.
        for (int n = 0; n < 1500; n++) begin
            r     = int'($urandom_range(0, 99));
            wren  = 1'b0;
            reset = 1'b1;
            data  = 32'h0;
            if (r < 1) begin
                reset = 1'b0;
            end else if (r < 30) begin
                ro      = 4'($urandom_range(0, 15));
                wren    = 1'b1;
                address = ($urandom_range(0, 9) == 0) ? 12'($urandom) : {8'hF0, ro};
                data    = rand_data(ro);
            end else if (r < 45) begin
                address = {8'hF0, 4'($urandom_range(0, 15))};
            end
            cycle();
        end
        reset = 1'b1;
        wren  = 1'b0;
        $display("random: 1500 cycles applied");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
